// File: rtl/cpu_bus_pkg.sv
// Shared types for the CPU memory-port arbiter: response owner, latency tag, bus widths.
package cpu_bus_pkg;

    localparam int BUS_ADDR_W = 32;
    localparam int BUS_DATA_W = 32;
    localparam int BE_W       = BUS_DATA_W / 8;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

    typedef struct packed {
        logic   valid;
        owner_e owner;
        logic   kill;
    } resp_tag_t;

    // A redirect poisons every in-flight fetch; data entries are never killed.
    function automatic resp_tag_t flush_kill(input resp_tag_t t, input logic flush);
        resp_tag_t r;
        r = t;
        if (flush && t.valid && t.owner == OWN_IF) r.kill = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/mem_resp_pipe.sv
// MEM_LAT-deep tag shift register tracking in-flight reads; the head entry lines up with mem_rdata.
module mem_resp_pipe
    import cpu_bus_pkg::*;
#(
    parameter int MEM_LAT = 2
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push_valid,
    input  owner_e push_owner,
    input  logic   flush,
    output logic   resp_valid,
    output owner_e resp_owner
);

    resp_tag_t stage [MEM_LAT];
    resp_tag_t head;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MEM_LAT; i++) stage[i] <= '0;
        end else begin
            stage[0] <= '{valid: push_valid, owner: push_owner, kill: 1'b0};
            for (int i = 1; i < MEM_LAT; i++) stage[i] <= flush_kill(stage[i-1], flush);
        end
    end

    // The exiting entry also sees a same-cycle flush.
    assign head       = flush_kill(stage[MEM_LAT-1], flush);
    assign resp_valid = head.valid && !head.kill;
    assign resp_owner = head.owner;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between IF and MEM stages; returns read data to its issuer.
// Define ARB_RR_EN for round-robin on conflicts; otherwise D has fixed priority over IF.
module mem_port_arbiter
    import cpu_bus_pkg::*;
#(
    parameter int ADDR_W  = BUS_ADDR_W,
    parameter int DATA_W  = BUS_DATA_W,
    parameter int MEM_LAT = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    input  logic                if_flush,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_ready,
    input  logic [DATA_W-1:0]   mem_rdata
);

    logic   if_act;
    logic   can_grant;
    logic   d_win;
    logic   resp_valid;
    owner_e resp_owner;

    assign if_act    = if_req && !if_flush;
    assign can_grant = mem_ready && !rst;

`ifdef ARB_RR_EN
    logic rr_fav_d;

    // The favoured requester wins a conflict, so every conflict grant flips the pointer.
    always_ff @(posedge clk) begin
        if (rst)                                rr_fav_d <= 1'b0;
        else if (can_grant && d_req && if_act)  rr_fav_d <= !rr_fav_d;
    end

    assign d_win = d_req && (!if_act || rr_fav_d);
`else
    assign d_win = d_req;
`endif

    always_comb begin
        d_gnt     = can_grant && d_win;
        if_gnt    = can_grant && if_act && !d_win;
        mem_req   = if_gnt || d_gnt;
        mem_we    = d_gnt && d_we;
        mem_be    = mem_we ? d_be : {(DATA_W/8){1'b1}};
        mem_addr  = d_gnt ? d_addr : if_addr;
        mem_wdata = d_wdata;
    end

    mem_resp_pipe #(.MEM_LAT(MEM_LAT)) u_resp_pipe (
        .clk        (clk),
        .rst        (rst),
        .push_valid (if_gnt || (d_gnt && !d_we)),
        .push_owner (d_gnt ? OWN_D : OWN_IF),
        .flush      (if_flush),
        .resp_valid (resp_valid),
        .resp_owner (resp_owner)
    );

    assign if_rvalid = !rst && resp_valid && resp_owner == OWN_IF;
    assign d_rvalid  = !rst && resp_valid && resp_owner == OWN_D;
    assign if_rdata  = mem_rdata;
    assign d_rdata   = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a read-response scoreboard.
module tb_mem_port_arbiter;
    import cpu_bus_pkg::*;

    localparam int LAT = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            if_req, if_flush, if_gnt, if_rvalid;
    logic [31:0]     if_addr, if_rdata;
    logic            d_req, d_we, d_gnt, d_rvalid;
    logic [BE_W-1:0] d_be, mem_be;
    logic [31:0]     d_addr, d_wdata, d_rdata;
    logic            mem_req, mem_we, mem_ready;
    logic [31:0]     mem_addr, mem_wdata, mem_rdata;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    // Fixed-latency memory model: accepted reads return mem_val(addr) LAT cycles later.
    logic [31:0] rd_line [LAT];
    always @(posedge clk) begin
        for (int i = LAT - 1; i > 0; i--) rd_line[i] <= rd_line[i-1];
        rd_line[0] <= (mem_req && mem_ready && !mem_we) ? mem_val(mem_addr) : 32'h0BAD_0BAD;
    end
    assign mem_rdata = rd_line[LAT-1];

    // Scoreboard: expected responses pushed on read grants, popped when due.
    typedef struct {
        int          due;
        bit          own_d;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    always @(negedge clk) begin
        bit          e_if, e_d;
        logic [31:0] x_if, x_d;
        e_if = 0; e_d = 0; x_if = '0; x_d = '0;
        if (rst) begin
            sb.delete();
        end else begin
            if (if_flush)
                for (int i = sb.size() - 1; i >= 0; i--)
                    if (!sb[i].own_d && sb[i].due >= cyc) sb.delete(i);
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].due <= cyc) begin
                    if (sb[i].own_d) begin e_d = 1; x_d = sb[i].data; end
                    else begin e_if = 1; x_if = sb[i].data; end
                    sb.delete(i);
                end
            end
        end
        n_tests++;
        if (if_rvalid !== e_if) begin n_fail++; $display("FAIL sb_if_rvalid cyc %0d: got %0b expected %0b", cyc, if_rvalid, e_if); end
        n_tests++;
        if (d_rvalid !== e_d) begin n_fail++; $display("FAIL sb_d_rvalid cyc %0d: got %0b expected %0b", cyc, d_rvalid, e_d); end
        if (e_if) begin
            n_tests++;
            if (if_rdata !== x_if) begin n_fail++; $display("FAIL sb_if_rdata cyc %0d: got %h expected %h", cyc, if_rdata, x_if); end
        end
        if (e_d) begin
            n_tests++;
            if (d_rdata !== x_d) begin n_fail++; $display("FAIL sb_d_rdata cyc %0d: got %h expected %h", cyc, d_rdata, x_d); end
        end
        if (!rst && if_gnt) sb.push_back('{cyc + LAT, 1'b0, mem_val(if_addr)});
        if (!rst && d_gnt && !d_we) sb.push_back('{cyc + LAT, 1'b1, mem_val(d_addr)});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_req = 0; if_flush = 0; d_req = 0; d_we = 0; d_be = '0;
    endtask

    task automatic test_reset();
        rst = 1; mem_ready = 1; idle_inputs();
        if_addr = '0; d_addr = '0; d_wdata = '0;
        if_req = 1; d_req = 1;
        tick(); tick();
        @(negedge clk);
        n_tests++;
        if ({if_gnt, d_gnt, mem_req, if_rvalid, d_rvalid} !== 5'b0) begin
            n_fail++; $display("FAIL reset_outputs: got %b expected 00000", {if_gnt, d_gnt, mem_req, if_rvalid, d_rvalid});
        end
        tick();
        rst = 0; idle_inputs();
    endtask

    task automatic test_basic_fetch();
        tick();
        if_req = 1; if_addr = 32'h0;
        @(negedge clk);
        n_tests++;
        if (if_gnt !== 1 || mem_req !== 1 || mem_addr !== 32'h0 || mem_be !== 4'hF || mem_we !== 0) begin
            n_fail++; $display("FAIL fetch_grant: got gnt=%0b req=%0b addr=%h be=%h we=%0b expected 1 1 0 f 0", if_gnt, mem_req, mem_addr, mem_be, mem_we);
        end
        tick(); if_req = 0;
        tick();
        @(negedge clk);
        n_tests++;
        if (if_rvalid !== 1 || if_rdata !== mem_val(32'h0)) begin
            n_fail++; $display("FAIL fetch_resp: got v=%0b data=%h expected 1 %h", if_rvalid, if_rdata, mem_val(32'h0));
        end
        tick();
    endtask

    task automatic test_conflict();
        bit first_d;
`ifdef ARB_RR_EN
        first_d = 0;
`else
        first_d = 1;
`endif
        tick();
        if_req = 1; if_addr = 32'h40; d_req = 1; d_we = 0; d_addr = 32'h100;
        @(negedge clk);
        n_tests++;
        if (d_gnt !== first_d || if_gnt !== !first_d) begin
            n_fail++; $display("FAIL conflict_first: got d=%0b if=%0b expected d=%0b", d_gnt, if_gnt, first_d);
        end
        tick();
        if (first_d) d_req = 0; else if_req = 0;
        @(negedge clk);
        n_tests++;
        if (d_gnt !== !first_d || if_gnt !== first_d) begin
            n_fail++; $display("FAIL conflict_second: got d=%0b if=%0b expected d=%0b", d_gnt, if_gnt, !first_d);
        end
        tick(); idle_inputs();
        @(negedge clk);
        n_tests++;
        if (d_rvalid !== first_d || if_rvalid !== !first_d) begin
            n_fail++; $display("FAIL conflict_resp1: got d=%0b if=%0b expected d=%0b", d_rvalid, if_rvalid, first_d);
        end
        tick();
        @(negedge clk);
        n_tests++;
        if (d_rvalid !== !first_d || if_rvalid !== first_d) begin
            n_fail++; $display("FAIL conflict_resp2: got d=%0b if=%0b expected d=%0b", d_rvalid, if_rvalid, !first_d);
        end
        tick();
    endtask

    task automatic test_rr_sequence();
        bit exp_if;
        rst = 1; tick(); rst = 0;
        if_req = 1; if_addr = 32'h80; d_req = 1; d_we = 0; d_addr = 32'h180;
        for (int i = 0; i < 4; i++) begin
`ifdef ARB_RR_EN
            exp_if = (i % 2 == 0);
`else
            exp_if = 0;
`endif
            @(negedge clk);
            n_tests++;
            if (if_gnt !== exp_if || d_gnt !== !exp_if) begin
                n_fail++; $display("FAIL dual_req_%0d: got if=%0b d=%0b expected if=%0b", i, if_gnt, d_gnt, exp_if);
            end
            tick();
        end
        idle_inputs();
        repeat (LAT + 1) tick();
    endtask

    task automatic test_flush();
        tick();
        if_req = 1; if_addr = 32'h300;
        @(negedge clk);
        n_tests++;
        if (if_gnt !== 1) begin n_fail++; $display("FAIL flush_pre_grant: got %0b expected 1", if_gnt); end
        tick();
        if_flush = 1; if_addr = 32'h400; d_req = 1; d_we = 0; d_addr = 32'h104;
        @(negedge clk);
        n_tests++;
        if (if_gnt !== 0 || d_gnt !== 1) begin
            n_fail++; $display("FAIL flush_grant: got if=%0b d=%0b expected if=0 d=1", if_gnt, d_gnt);
        end
        tick(); idle_inputs();
        @(negedge clk);
        n_tests++;
        if (if_rvalid !== 0) begin n_fail++; $display("FAIL flush_killed: got if_rvalid=%0b expected 0", if_rvalid); end
        tick();
        @(negedge clk);
        n_tests++;
        if (d_rvalid !== 1 || d_rdata !== mem_val(32'h104)) begin
            n_fail++; $display("FAIL flush_d_resp: got v=%0b data=%h expected 1 %h", d_rvalid, d_rdata, mem_val(32'h104));
        end
        tick();
    endtask

    task automatic test_store();
        tick();
        d_req = 1; d_we = 1; d_be = 4'b0011; d_addr = 32'h200; d_wdata = 32'hDEADBEEF;
        @(negedge clk);
        n_tests++;
        if (d_gnt !== 1 || mem_req !== 1 || mem_we !== 1 || mem_be !== 4'b0011 ||
            mem_addr !== 32'h200 || mem_wdata !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL store_fields: got gnt=%0b req=%0b we=%0b be=%b addr=%h wdata=%h expected 1 1 1 0011 200 deadbeef",
                               d_gnt, mem_req, mem_we, mem_be, mem_addr, mem_wdata);
        end
        tick(); idle_inputs();
        tick();
        @(negedge clk);
        n_tests++;
        if (d_rvalid !== 0) begin n_fail++; $display("FAIL store_no_rvalid: got %0b expected 0", d_rvalid); end
        tick();
    endtask

    task automatic test_reset_inflight_and_stall();
        tick();
        if_req = 1; if_addr = 32'h10;
        @(negedge clk);
        n_tests++;
        if (if_gnt !== 1) begin n_fail++; $display("FAIL rst_if_grant: got %0b expected 1", if_gnt); end
        tick();
        if_req = 0; d_req = 1; d_we = 0; d_addr = 32'h20;
        @(negedge clk);
        n_tests++;
        if (d_gnt !== 1) begin n_fail++; $display("FAIL rst_d_grant: got %0b expected 1", d_gnt); end
        tick();
        rst = 1;
        @(negedge clk);
        n_tests++;
        if (d_gnt !== 0 || mem_req !== 0 || if_rvalid !== 0) begin
            n_fail++; $display("FAIL rst_inflight: got gnt=%0b req=%0b if_rvalid=%0b expected 0 0 0", d_gnt, mem_req, if_rvalid);
        end
        tick();
        rst = 0; d_req = 0;
        @(negedge clk);
        n_tests++;
        if (d_rvalid !== 0 || if_rvalid !== 0) begin
            n_fail++; $display("FAIL rst_discard: got d=%0b if=%0b expected 0 0", d_rvalid, if_rvalid);
        end
        tick();
        if_req = 1; if_addr = 32'h44;
        @(negedge clk);
        n_tests++;
        if (if_gnt !== 1) begin n_fail++; $display("FAIL stall_pre_grant: got %0b expected 1", if_gnt); end
        tick();
        if_req = 0; d_req = 1; d_addr = 32'h48; mem_ready = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_tests++;
            if (d_gnt !== 0 || mem_req !== 0) begin
                n_fail++; $display("FAIL stall_no_grant_%0d: got gnt=%0b req=%0b expected 0 0", i, d_gnt, mem_req);
            end
            if (i == 1) begin
                n_tests++;
                if (if_rvalid !== 1 || if_rdata !== mem_val(32'h44)) begin
                    n_fail++; $display("FAIL stall_drain: got v=%0b data=%h expected 1 %h", if_rvalid, if_rdata, mem_val(32'h44));
                end
            end
            tick();
        end
        idle_inputs(); mem_ready = 1;
        repeat (LAT + 1) tick();
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_conflict();
        test_rr_sequence();
        test_flush();
        test_store();
        test_reset_inflight_and_stall();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
